// File: rtl/odd_parity_serial_tx.sv
// Odd-parity serial transmitter: accepts a word over valid/ready and sends
// start(0), data LSB first, odd-parity bit, stop(1), each bit CLKS_PER_BIT cycles.
module odd_parity_serial_tx #(
    parameter int DATA_W       = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              tx_out,
    output logic              parity_out,
    output logic              busy,
    output logic              frame_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam int BIT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    function automatic logic odd_parity(input logic [DATA_W-1:0] word);
        return ~^word;
    endfunction

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  cyc_q, cyc_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic              parity_q, parity_d;
    logic              tx_q, tx_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              bit_end_s;

    // Next-state logic; outputs are derived from the next state so they register in step with it
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cyc_d     = cyc_q;
        bit_d     = bit_q;
        parity_d  = parity_q;
        bit_end_s = (cyc_q == CNT_LAST);

        case (state_q)
            S_IDLE: begin
                if (data_valid && ready_q) begin
                    shreg_d  = data_in;
                    parity_d = odd_parity(data_in);
                    cyc_d    = {CNT_W{1'b0}};
                    bit_d    = {BIT_W{1'b0}};
                    state_d  = S_START;
                end else begin
                    cyc_d = {CNT_W{1'b0}};
                end
            end
            S_START: begin
                if (bit_end_s) begin
                    cyc_d   = {CNT_W{1'b0}};
                    state_d = S_DATA;
                end else begin
                    cyc_d = cyc_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (bit_end_s) begin
                    cyc_d   = {CNT_W{1'b0}};
                    shreg_d = shreg_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = {BIT_W{1'b0}};
                        state_d = S_PARITY;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    cyc_d = cyc_q + CNT_W'(1);
                end
            end
            S_PARITY: begin
                if (bit_end_s) begin
                    cyc_d   = {CNT_W{1'b0}};
                    state_d = S_STOP;
                end else begin
                    cyc_d = cyc_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (bit_end_s) begin
                    cyc_d   = {CNT_W{1'b0}};
                    state_d = S_IDLE;
                end else begin
                    cyc_d = cyc_q + CNT_W'(1);
                end
            end
            default: begin
                cyc_d   = {CNT_W{1'b0}};
                bit_d   = {BIT_W{1'b0}};
                state_d = S_IDLE;
            end
        endcase

        case (state_d)
            S_IDLE:   tx_d = 1'b1;
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shreg_d[0];
            S_PARITY: tx_d = parity_d;
            S_STOP:   tx_d = 1'b1;
            default:  tx_d = 1'b1;
        endcase

        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_STOP) && (cyc_d == CNT_LAST);
    end

    // State and registered outputs with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            shreg_q  <= {DATA_W{1'b0}};
            cyc_q    <= {CNT_W{1'b0}};
            bit_q    <= {BIT_W{1'b0}};
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cyc_q    <= cyc_d;
            bit_q    <= bit_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign data_ready = ready_q;
    assign tx_out     = tx_q;
    assign parity_out = parity_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_odd_parity_serial_tx.sv
// Directed bench for odd_parity_serial_tx: a 4-bit/4-cycle instance and a
// 1-bit/1-cycle instance sharing clock and reset.
module tb_odd_parity_serial_tx;

    localparam int DW  = 4;
    localparam int CPB = 4;
    localparam int FL  = (DW + 3) * CPB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [DW-1:0] data_in;
    logic          data_valid;
    logic          data_ready, tx_out, parity_out, busy, frame_done;

    logic [0:0]    data_in_b;
    logic          valid_b;
    logic          ready_b, tx_b, parity_b, busy_b, done_b;

    int checks = 0;
    int passed = 0;

    logic tx_cap   [FL];
    logic done_cap [FL];

    odd_parity_serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .tx_out(tx_out), .parity_out(parity_out),
        .busy(busy), .frame_done(frame_done)
    );

    odd_parity_serial_tx #(.DATA_W(1), .CLKS_PER_BIT(1)) dut_small (
        .clk(clk), .rst_n(rst_n), .data_in(data_in_b), .data_valid(valid_b),
        .data_ready(ready_b), .tx_out(tx_b), .parity_out(parity_b),
        .busy(busy_b), .frame_done(done_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for ready, accepts one word and captures the FL frame cycles.
    task automatic run_frame(input logic [DW-1:0] w);
        int n = 0;
        while (!data_ready && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (data_ready !== 1'b1) $display("FAIL accept_wait ready=%0b required=1", data_ready);
        else passed++;
        data_in    = w;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        for (int i = 0; i < FL; i++) begin
            tx_cap[i]   = tx_out;
            done_cap[i] = frame_done;
            if (i < FL - 1) tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; data_valid = 1'b0; data_in = '0; valid_b = 1'b0; data_in_b = 1'b0;
        tick(); tick();
        checks++;
        if ({tx_out, data_ready, busy, frame_done, parity_out} !== 5'b11000)
            $display("FAIL reset_outputs got=%b required=11000",
                     {tx_out, data_ready, busy, frame_done, parity_out});
        else passed++;
        rst_n = 1'b1;
        tick();
        checks++;
        if ({tx_out, data_ready, busy} !== 3'b110)
            $display("FAIL idle_after_reset got=%b required=110", {tx_out, data_ready, busy});
        else passed++;
    endtask

    task automatic test_frame(input string name, input logic [DW-1:0] w,
                              input logic [6:0] exp_bits, input logic exp_par);
        logic ok;
        logic [FL-1:0] dv;
        run_frame(w);
        for (int b = 0; b < 7; b++) begin
            ok = 1'b1;
            for (int c = 0; c < CPB; c++)
                if (tx_cap[b*CPB+c] !== exp_bits[b]) ok = 1'b0;
            checks++;
            if (!ok) $display("FAIL %s_bit%0d got=%b required=%b", name, b, tx_cap[b*CPB], exp_bits[b]);
            else passed++;
        end
        for (int i = 0; i < FL; i++) dv[i] = done_cap[i];
        checks++;
        if (dv !== {1'b1, {(FL-1){1'b0}}}) $display("FAIL %s_done got=%h required=%h", name, dv, {1'b1, {(FL-1){1'b0}}});
        else passed++;
        checks++;
        if (parity_out !== exp_par) $display("FAIL %s_parity got=%b required=%b", name, parity_out, exp_par);
        else passed++;
        tick();
        checks++;
        if ({data_ready, busy, tx_out, frame_done} !== 4'b1010)
            $display("FAIL %s_after got=%b required=1010", name, {data_ready, busy, tx_out, frame_done});
        else passed++;
    endtask

    // Deserialize each frame at mid-bit and apply an odd-parity checker.
    task automatic test_sweep();
        logic [DW-1:0] rx;
        logic st, par, sp, err;
        for (int w = 0; w < 16; w++) begin
            run_frame(w[DW-1:0]);
            st = tx_cap[CPB/2];
            for (int b = 0; b < DW; b++) rx[b] = tx_cap[(b+1)*CPB + CPB/2];
            par = tx_cap[(DW+1)*CPB + CPB/2];
            sp  = tx_cap[(DW+2)*CPB + CPB/2];
            err = ~(^{rx, par}) | st | ~sp;
            checks++;
            if (err !== 1'b0) $display("FAIL sweep_err word=%0d got=%b required=0", w, err);
            else passed++;
            checks++;
            if (rx !== w[DW-1:0]) $display("FAIL sweep_data got=%h required=%h", rx, w[DW-1:0]);
            else passed++;
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int n;
        logic ok;
        logic [6:0] exp5;
        exp5 = 7'b1101010;
        data_in = 4'hA; data_valid = 1'b1;
        tick();
        data_in = 4'h5;
        n = 1;
        while (!frame_done && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n !== FL) $display("FAIL b2b_len got=%0d required=%0d", n, FL);
        else passed++;
        checks++;
        if (parity_out !== 1'b1) $display("FAIL b2b_parityA got=%b required=1", parity_out);
        else passed++;
        tick();
        checks++;
        if ({data_ready, busy, tx_out} !== 3'b101)
            $display("FAIL b2b_gap got=%b required=101", {data_ready, busy, tx_out});
        else passed++;
        tick();
        checks++;
        if ({data_ready, busy, tx_out} !== 3'b010)
            $display("FAIL b2b_second_accept got=%b required=010", {data_ready, busy, tx_out});
        else passed++;
        for (int i = 0; i < FL; i++) begin
            tx_cap[i]   = tx_out;
            done_cap[i] = frame_done;
            data_valid  = i[0];
            if (i < FL - 1) tick();
        end
        data_valid = 1'b0;
        ok = 1'b1;
        for (int b = 0; b < 7; b++)
            for (int c = 0; c < CPB; c++)
                if (tx_cap[b*CPB+c] !== exp5[b]) ok = 1'b0;
        checks++;
        if (!ok || done_cap[FL-1] !== 1'b1) $display("FAIL b2b_frameB ok=%b done=%b required=1,1", ok, done_cap[FL-1]);
        else passed++;
        checks++;
        if (parity_out !== 1'b1) $display("FAIL b2b_parityB got=%b required=1", parity_out);
        else passed++;
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (busy !== 1'b0 || tx_out !== 1'b1) ok = 1'b0;
        end
        checks++;
        if (!ok) $display("FAIL b2b_no_extra busy=%b required=0", busy);
        else passed++;
    endtask

    task automatic test_mid_reset();
        logic ok;
        data_in = 4'hF; data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        checks++;
        if ({busy, tx_out} !== 2'b11) $display("FAIL rst_pre got=%b required=11", {busy, tx_out});
        else passed++;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if ({tx_out, busy, data_ready, frame_done, parity_out} !== 5'b10100)
            $display("FAIL rst_mid got=%b required=10100",
                     {tx_out, busy, data_ready, frame_done, parity_out});
        else passed++;
        ok = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (frame_done !== 1'b0 || busy !== 1'b0) ok = 1'b0;
        end
        checks++;
        if (!ok) $display("FAIL rst_no_done done=%b busy=%b required=0,0", frame_done, busy);
        else passed++;
    endtask

    task automatic test_small();
        logic [3:0] got, dn;
        checks++;
        if (ready_b !== 1'b1) $display("FAIL small_ready got=%b required=1", ready_b);
        else passed++;
        data_in_b = 1'b1; valid_b = 1'b1;
        tick();
        valid_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            got[i] = tx_b;
            dn[i]  = done_b;
            if (i < 3) tick();
        end
        checks++;
        if (got !== 4'b1010) $display("FAIL small_frame got=%b required=1010", got);
        else passed++;
        checks++;
        if (dn !== 4'b1000) $display("FAIL small_done got=%b required=1000", dn);
        else passed++;
        checks++;
        if (parity_b !== 1'b0) $display("FAIL small_parity got=%b required=0", parity_b);
        else passed++;
        tick();
        checks++;
        if ({ready_b, busy_b, tx_b} !== 3'b101) $display("FAIL small_after got=%b required=101", {ready_b, busy_b, tx_b});
        else passed++;
    endtask

    initial begin
        test_reset();
        test_frame("zero", 4'b0000, 7'b1100000, 1'b1);
        test_frame("w0111", 4'b0111, 7'b1001110, 1'b0);
        test_sweep();
        test_back_to_back();
        test_mid_reset();
        test_small();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
